// File: rtl/tx_frame_arbiter.sv
// Frame-level round-robin arbiter: two byte FIFOs with length descriptors feeding one MAC TX stream.
// Oversize frames are drained and counted; every transmitted frame is followed by an idle gap.
module tx_frame_arbiter #(
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 11,
  parameter int MAX_LEN    = 1518,
  parameter int IFG_CYCLES = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              len_valid_0,
  input  logic [LEN_W-1:0]  len_0,
  output logic              len_pop_0,
  output logic              rd_0,
  input  logic [DATA_W-1:0] data_0,
  input  logic              len_valid_1,
  input  logic [LEN_W-1:0]  len_1,
  output logic              len_pop_1,
  output logic              rd_1,
  input  logic [DATA_W-1:0] data_1,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              tx_last,
  input  logic              tx_ready,
  output logic              grant,
  output logic              busy,
  output logic [15:0]       drop_cnt
);

  localparam int IFG_W = $clog2(IFG_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEND = 3'd2,
    DROP = 3'd3,
    IFG  = 3'd4
  } state_e;

  state_e             state_q;
  logic [LEN_W-1:0]   rem_q;
  logic [IFG_W-1:0]   ifg_q;
  logic               grant_q;
  logic               last_grant_q;
  logic               pop0_q;
  logic               pop1_q;
  logic               busy_q;
  logic [15:0]        drop_q;
  logic               inflight_q;
  logic               inflight_last_q;

  // Two-entry skid FIFO; entry 0 is the head and directly drives the MAC stream.
  logic               v0_q;
  logic               v1_q;
  logic               l0_q;
  logic               l1_q;
  logic [DATA_W-1:0]  d0_q;
  logic [DATA_W-1:0]  d1_q;

  logic               pop_s;
  logic [1:0]         occ_s;
  logic               rd_s;
  logic               win_s;
  logic [DATA_W-1:0]  new_data_s;

  // Read credit, winner selection and returning-data mux.
  always_comb begin
    pop_s      = v0_q & tx_ready;
    occ_s      = 2'(v0_q) + 2'(v1_q) + 2'(inflight_q) - 2'(pop_s);
    rd_s       = 1'b0;
    win_s      = 1'b0;
    new_data_s = data_0;
    case (state_q)
      SEND:    rd_s = (rem_q != {LEN_W{1'b0}}) && (occ_s < 2'd2);
      DROP:    rd_s = (rem_q != {LEN_W{1'b0}});
      default: rd_s = 1'b0;
    endcase
    if (len_valid_0 && len_valid_1) begin
      win_s = ~last_grant_q;
    end else begin
      win_s = len_valid_1;
    end
    if (grant_q) begin
      new_data_s = data_1;
    end else begin
      new_data_s = data_0;
    end
  end

  // Frame FSM: grant, descriptor pop, byte countdown, drop counting and gap timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      rem_q           <= {LEN_W{1'b0}};
      ifg_q           <= {IFG_W{1'b0}};
      grant_q         <= 1'b0;
      last_grant_q    <= 1'b1;
      pop0_q          <= 1'b0;
      pop1_q          <= 1'b0;
      busy_q          <= 1'b0;
      drop_q          <= 16'd0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      pop0_q          <= 1'b0;
      pop1_q          <= 1'b0;
      inflight_q      <= (state_q == SEND) && rd_s;
      inflight_last_q <= (state_q == SEND) && rd_s && (rem_q == LEN_W'(1));
      if (rd_s) begin
        rem_q <= rem_q - LEN_W'(1);
      end
      case (state_q)
        IDLE: begin
          if (len_valid_0 || len_valid_1) begin
            grant_q <= win_s;
            rem_q   <= win_s ? len_1 : len_0;
            pop0_q  <= ~win_s;
            pop1_q  <= win_s;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (rem_q == {LEN_W{1'b0}}) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (rem_q > LEN_W'(MAX_LEN)) begin
            state_q <= DROP;
          end else begin
            last_grant_q <= grant_q;
            state_q      <= SEND;
          end
        end
        SEND: begin
          if (pop_s && l0_q) begin
            ifg_q   <= IFG_W'(IFG_CYCLES - 1);
            state_q <= IFG;
          end
        end
        DROP: begin
          if (rem_q == {LEN_W{1'b0}}) begin
            if (drop_q != 16'hFFFF) begin
              drop_q <= drop_q + 16'd1;
            end
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        IFG: begin
          if (ifg_q == {IFG_W{1'b0}}) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            ifg_q <= ifg_q - IFG_W'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Skid FIFO: push returning bytes, shift on MAC handshake, hold head while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      l0_q <= 1'b0;
      l1_q <= 1'b0;
      d0_q <= {DATA_W{1'b0}};
      d1_q <= {DATA_W{1'b0}};
    end else begin
      case ({inflight_q, pop_s})
        2'b11: begin
          if (v1_q) begin
            d0_q <= d1_q;
            l0_q <= l1_q;
            d1_q <= new_data_s;
            l1_q <= inflight_last_q;
          end else begin
            d0_q <= new_data_s;
            l0_q <= inflight_last_q;
          end
        end
        2'b10: begin
          if (v0_q) begin
            d1_q <= new_data_s;
            l1_q <= inflight_last_q;
            v1_q <= 1'b1;
          end else begin
            d0_q <= new_data_s;
            l0_q <= inflight_last_q;
            v0_q <= 1'b1;
          end
        end
        2'b01: begin
          d0_q <= d1_q;
          l0_q <= l1_q;
          v0_q <= v1_q;
          v1_q <= 1'b0;
          l1_q <= 1'b0;
        end
        default: begin
          v0_q <= v0_q;
        end
      endcase
    end
  end

  assign rd_0      = rd_s & ~grant_q;
  assign rd_1      = rd_s & grant_q;
  assign len_pop_0 = pop0_q;
  assign len_pop_1 = pop1_q;
  assign tx_data   = d0_q;
  assign tx_valid  = v0_q;
  assign tx_last   = v0_q & l0_q;
  assign grant     = grant_q;
  assign busy      = busy_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Scoreboard bench for tx_frame_arbiter: modelled upstream FIFOs/descriptor queues,
// per-port expected byte queues, and a negedge monitor applying the arbitration rules.
module tb_tx_frame_arbiter;

  localparam int DATA_W     = 8;
  localparam int LEN_W      = 11;
  localparam int MAX_LEN    = 1518;
  localparam int IFG_CYCLES = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              len_valid_0 = 1'b0, len_valid_1 = 1'b0;
  logic [LEN_W-1:0]  len_0 = '0, len_1 = '0;
  logic              len_pop_0, len_pop_1, rd_0, rd_1;
  logic [DATA_W-1:0] data_0 = '0, data_1 = '0;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid, tx_last;
  logic              tx_ready = 1'b1;
  logic              grant, busy;
  logic [15:0]       drop_cnt;

  always #5 clk = ~clk;

  tx_frame_arbiter #(.DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_LEN(MAX_LEN), .IFG_CYCLES(IFG_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .len_valid_0(len_valid_0), .len_0(len_0), .len_pop_0(len_pop_0), .rd_0(rd_0), .data_0(data_0),
    .len_valid_1(len_valid_1), .len_1(len_1), .len_pop_1(len_pop_1), .rd_1(rd_1), .data_1(data_1),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .grant(grant), .busy(busy), .drop_cnt(drop_cnt)
  );

  logic [7:0] fifo_q0[$], fifo_q1[$];
  int         desc_q0[$], desc_q1[$];
  logic [8:0] exp_q0[$], exp_q1[$];
  int         pop_log[$];

  int vec_cnt = 0, err_cnt = 0, cyc = 0;
  bit rd0_seen, rd1_seen, pop0_seen, pop1_seen;
  int rd0_tot = 0, rd1_tot = 0, pop0_tot = 0, pop1_tot = 0, hs_tot = 0, txv_tot = 0;
  int drop_m = 0;
  bit last_grant_m = 1'b1, cur_port_m = 1'b0;
  bit sent_flag = 1'b0, want_first = 1'b0;
  int last_hs_cyc = 0, last_gap = 0, last_pop_cyc = 0, lat_last = 0, last_rd1_cyc = 0;
  bit both_prev = 1'b0, v1_prev = 1'b0;
  bit stall_prev = 1'b0;
  logic [8:0] stall_val;
  int ready_mode = 0;
  bit mon_p, mon_w;
  int mon_len;
  logic [8:0] mon_e;

  task automatic chk(input string nm, input longint act, input longint exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Upstream model: FIFO data one cycle after rd, descriptor queue head, MAC ready pattern.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rd0_seen && fifo_q0.size() > 0) data_0 = fifo_q0.pop_front();
      if (rd1_seen && fifo_q1.size() > 0) data_1 = fifo_q1.pop_front();
      if (pop0_seen && desc_q0.size() > 0) void'(desc_q0.pop_front());
      if (pop1_seen && desc_q1.size() > 0) void'(desc_q1.pop_front());
      len_valid_0 = (desc_q0.size() > 0);
      len_valid_1 = (desc_q1.size() > 0);
      len_0 = (desc_q0.size() > 0) ? LEN_W'(desc_q0[0]) : '0;
      len_1 = (desc_q1.size() > 0) ? LEN_W'(desc_q1[0]) : '0;
      case (ready_mode)
        1:       tx_ready = ~tx_ready;
        2:       tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = 1'b1;
      endcase
    end
  end

  // Monitor: arbitration rule, port exclusivity, byte scoreboard, stall stability, gap timing.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      rd0_seen = 0; rd1_seen = 0; pop0_seen = 0; pop1_seen = 0; stall_prev = 0;
    end else begin
      rd0_seen = rd_0; rd1_seen = rd_1; pop0_seen = len_pop_0; pop1_seen = len_pop_1;
      if (rd_0) rd0_tot++;
      if (rd_1) begin rd1_tot++; last_rd1_cyc = cyc; end
      if (rd_0 || rd_1) chk("rd_port_granted", rd_1, grant);
      if (len_pop_0 || len_pop_1) begin
        chk("pop_exclusive", len_pop_0 & len_pop_1, 0);
        mon_p = len_pop_1;
        mon_w = both_prev ? !last_grant_m : v1_prev;
        chk("arb_winner", mon_p, mon_w);
        chk("pop_grant", grant, mon_p);
        pop_log.push_back(int'(mon_p));
        if (mon_p) pop1_tot++; else pop0_tot++;
        mon_len = mon_p ? ((desc_q1.size() > 0) ? desc_q1[0] : -1) : ((desc_q0.size() > 0) ? desc_q0[0] : -1);
        chk("pop_has_descriptor", mon_len >= 0, 1);
        if (sent_flag) begin
          last_gap = cyc - last_hs_cyc;
          chk("ifg_min_gap", last_gap >= IFG_CYCLES + 2, 1);
          sent_flag = 0;
        end
        if (mon_len >= 1 && mon_len <= MAX_LEN) begin
          last_grant_m = mon_p; cur_port_m = mon_p; want_first = 1; last_pop_cyc = cyc;
        end else if (mon_len > MAX_LEN && drop_m < 65535) begin
          drop_m++;
        end
      end
      if (tx_valid) txv_tot++;
      if (stall_prev) chk("stall_hold", {tx_valid, tx_last, tx_data}, {1'b1, stall_val});
      if (tx_valid && want_first) begin lat_last = cyc - last_pop_cyc; want_first = 0; end
      if (tx_valid && tx_ready) begin
        hs_tot++;
        chk("tx_grant", grant, cur_port_m);
        if ((cur_port_m ? exp_q1.size() : exp_q0.size()) == 0) begin
          chk("unexpected_byte", 1, 0);
        end else begin
          mon_e = cur_port_m ? exp_q1.pop_front() : exp_q0.pop_front();
          chk("tx_byte", {tx_last, tx_data}, mon_e);
        end
        if (tx_last) begin sent_flag = 1; last_hs_cyc = cyc; end
      end
      stall_prev = tx_valid && !tx_ready;
      stall_val  = {tx_last, tx_data};
    end
    both_prev = len_valid_0 && len_valid_1;
    v1_prev   = len_valid_1;
  end

  task automatic enqueue(input bit p, input int len, input bit fixed);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = fixed ? 8'(8'hA0 + i) : 8'($urandom);
      if (p) fifo_q1.push_back(b); else fifo_q0.push_back(b);
      if (len <= MAX_LEN) begin
        if (p) exp_q1.push_back({(i == len - 1), b}); else exp_q0.push_back({(i == len - 1), b});
      end
    end
    if (p) desc_q1.push_back(len); else desc_q0.push_back(len);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((desc_q0.size() + desc_q1.size() + exp_q0.size() + exp_q1.size() != 0 || busy) && n < budget) begin
      @(negedge clk); #1; n++;
    end
    chk("idle_timeout", n < budget, 1);
    chk("drop_cnt", drop_cnt, drop_m);
    chk("fifos_drained", fifo_q0.size() + fifo_q1.size(), 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_last", tx_last, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_rd", {rd_0, rd_1}, 0);
    chk("rst_len_pop", {len_pop_0, len_pop_1}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
  endtask

  task automatic clear_model();
    fifo_q0.delete(); fifo_q1.delete(); desc_q0.delete(); desc_q1.delete();
    exp_q0.delete(); exp_q1.delete();
    rd0_seen = 0; rd1_seen = 0; pop0_seen = 0; pop1_seen = 0;
    drop_m = 0; last_grant_m = 1'b1; sent_flag = 0; want_first = 0; stall_prev = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int r0, r1, p0, p1, h0, t0, n, len, rr;

  initial begin
    #1 check_reset_outputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single 4-byte frame on port0.
    r0 = rd0_tot; p0 = pop0_tot; h0 = hs_tot;
    enqueue(1'b0, 4, 1'b1);
    wait_idle(200);
    chk("t1_rd0_pulses", rd0_tot - r0, 4);
    chk("t1_pop0", pop0_tot - p0, 1);
    chk("t1_handshakes", hs_tot - h0, 4);
    chk("t1_first_valid_latency", lat_last, 3);

    // Simultaneous requests from reset, then port0 refill.
    pulse_reset();
    pop_log.delete();
    enqueue(1'b0, 3, 1'b0);
    enqueue(1'b1, 2, 1'b0);
    n = 0;
    while (hs_tot == h0 + 4 && n < 100) begin @(negedge clk); n++; end
    enqueue(1'b0, 5, 1'b0);
    wait_idle(300);
    chk("t2_pop_count", pop_log.size(), 3);
    if (pop_log.size() == 3) begin
      chk("t2_order0", pop_log[0], 0);
      chk("t2_order1", pop_log[1], 1);
      chk("t2_order2", pop_log[2], 0);
    end
    chk("t2_exact_gap", last_gap, IFG_CYCLES + 2);

    // 64-byte frame with alternating back-pressure.
    ready_mode = 1;
    h0 = hs_tot;
    enqueue(1'b1, 64, 1'b0);
    wait_idle(500);
    chk("t3_handshakes", hs_tot - h0, 64);
    ready_mode = 0;

    // Oversize frame on port1 dropped; waiting port0 frame follows without a gap.
    r0 = rd0_tot; r1 = rd1_tot; t0 = txv_tot;
    enqueue(1'b1, 1600, 1'b0);
    repeat (2) @(negedge clk);
    enqueue(1'b0, 6, 1'b0);
    wait_idle(3000);
    chk("t4_rd1_pulses", rd1_tot - r1, 1600);
    chk("t4_rd0_pulses", rd0_tot - r0, 6);
    chk("t4_drop_cnt_one", drop_cnt, 1);
    chk("t4_tx_valid_cycles", txv_tot - t0, 6);
    chk("t4_no_ifg", last_pop_cyc - last_rd1_cyc, 3);

    // Zero-length descriptor: one pop, nothing read or sent, last grant unchanged.
    pop_log.delete();
    r0 = rd0_tot; r1 = rd1_tot; p1 = pop1_tot; t0 = txv_tot;
    enqueue(1'b1, 0, 1'b0);
    wait_idle(100);
    chk("t5_pop1", pop1_tot - p1, 1);
    chk("t5_no_rd", (rd0_tot - r0) + (rd1_tot - r1), 0);
    chk("t5_no_tx", txv_tot - t0, 0);
    enqueue(1'b0, 2, 1'b0);
    enqueue(1'b1, 2, 1'b0);
    wait_idle(200);
    chk("t5_pop_count", pop_log.size(), 3);
    if (pop_log.size() == 3) chk("t5_winner_after_zero", pop_log[1], 1);

    // Reset in the middle of a 20-byte frame, then a fresh frame.
    h0 = hs_tot;
    enqueue(1'b0, 20, 1'b0);
    n = 0;
    while (hs_tot - h0 < 10 && n < 200) begin @(negedge clk); n++; end
    chk("t6_reach_byte10", n < 200, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    h0 = hs_tot;
    enqueue(1'b0, 5, 1'b0);
    wait_idle(200);
    chk("t6_fresh_frame", hs_tot - h0, 5);

    // Length boundaries, then randomized traffic with random back-pressure.
    ready_mode = 2;
    enqueue(1'b0, MAX_LEN + 1, 1'b0);
    enqueue(1'b1, MAX_LEN, 1'b0);
    wait_idle(8000);
    for (int it = 0; it < 60; it++) begin
      rr = $urandom_range(0, 19);
      case (rr)
        0:       len = 0;
        1:       len = MAX_LEN + 1 + $urandom_range(0, 10);
        2:       len = 1;
        default: len = $urandom_range(1, 24);
      endcase
      enqueue(1'($urandom_range(0, 1)), len, 1'b0);
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    wait_idle(60000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
